// File: rtl/clk_div_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : clk_div_pkg
//  Purpose  : Shared types, constants and helpers for the clock manager
//             (lock FSM state encoding, synchroniser depth, divisor
//             normalisation).
//  Revision : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    // Lock-qualification FSM states
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Number of flops in the pll_lock synchroniser
    localparam int SYNC_DEPTH = 2;

    // A programmed divisor of zero is meaningless; treat it as divide-by-one.
    // Operates on 32 bits so callers of any DIV_W <= 32 can share it.
    function automatic logic [31:0] div_norm(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : clk_div_chan
//  Purpose  : One clock-enable divider channel. Counts 0..D-1 while running
//             and emits a registered one-cycle ce pulse per wrap. A divisor
//             written while running is held pending and only becomes active
//             on a wrap, so a period is never cut short or stretched.
//  Macro    : CLK_DIV_MGR_SQ_EN - builds a toggle flop giving a 50 % square
//             wave at f/(2D); otherwise sq_o is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o,
    output logic             sq_o
);

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             ce_q, ce_d;
    logic [DIV_W-1:0] div_n;
    logic             wrap;

    assign div_n = DIV_W'(div_norm(32'(div_i)));
    assign wrap  = run_i && (cnt_q == act_q - ONE);

    // Next-state for counter, divisor registers and enable pulse
    always_comb begin
        cnt_d  = '0;
        act_d  = act_q;
        pend_d = pend_q;
        ce_d   = wrap;
        if (wr_i) begin
            pend_d = div_n;
        end
        if (!run_i) begin
            // Idle: counter parked at zero, latest programmed value is live
            act_d = wr_i ? div_n : pend_q;
        end else if (wrap) begin
            // A write landing on the wrap edge governs the new period
            act_d = wr_i ? div_n : pend_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            act_q  <= DIV_INIT;
            pend_q <= DIV_INIT;
            ce_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_o = ce_q;

`ifdef CLK_DIV_MGR_SQ_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = run_i ? (sq_q ^ wrap) : 1'b0;
    end

    // Square-wave toggle flop, flips on every ce pulse
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;
`else
    assign sq_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/clk_div_mgr.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : clk_div_mgr
//  Purpose  : Clock manager behind the PLL. Synchronises and qualifies the
//             PLL lock flag, sequences the downstream reset and drives
//             CH_NUM programmable clock-enable channels.
//  Macro    : CLK_DIV_MGR_SQ_EN - enables per-channel 50 % square outputs
//             on clk_sq; when undefined clk_sq is constant zero.
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_mgr
    import clk_div_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int DIV_RST     = 2,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pll_lock,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              locked,
    output logic              rst_out_n,
    output logic [CH_NUM-1:0] ce,
    output logic [CH_NUM-1:0] clk_sq
);

    localparam int               CNT_W    = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  lock_s;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  run_q;
    logic                  chan_run;
    logic [CH_NUM-1:0]     wr_sel;

    // Bring the asynchronous lock flag into the sys_clk domain
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_DEPTH-1];

    // Lock FSM next state: the stability counter tracks consecutive lock
    // cycles in STABLE and is cleared whenever lock is lost
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // FSM state, stability counter and registered RUN flag
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign locked    = run_q;
    assign rst_out_n = run_q;

    // Channels count only once the released reset is visible and stop on the
    // same edge it is withdrawn, so ce never pulses while rst_out_n is low
    assign chan_run = run_q && (state_d == RUN);

    // Route the write strobe to the addressed channel; out-of-range indices
    // match no channel and are dropped
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (cfg_wr && (int'(cfg_ch) == i)) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk_i  (sys_clk),
            .rst_ni (sys_rst_n),
            .run_i  (chan_run),
            .wr_i   (wr_sel[g]),
            .div_i  (cfg_div),
            .ce_o   (ce[g]),
            .sq_o   (clk_sq[g])
        );
    end

endmodule
`default_nettype wire

// File: doc/clk_div_mgr.md
# clk_div_mgr

Parametrised clock manager that sits directly behind the board PLL on the PLL output clock. It qualifies the PLL lock flag, sequences a clean system reset, and generates CH_NUM independently programmable clock-enable channels, with optional 50 % square-wave outputs. Downstream logic runs on the single PLL clock and gates activity with `ce[]` instead of instantiating extra PLL outputs or dividers.

## Interface
- `CH_NUM`, 4: number of divider channels (1..16).
- `DIV_W`, 16: divisor width.
- `LOCK_CYCLES`, 1024: consecutive synchronised-lock cycles required before release (≥2).
- `DIV_RST`, 2: divisor loaded into every channel at reset.

Ports:
- `sys_clk`  in  1  PLL output clock; sole clock.
- `sys_rst_n`  in  1  synchronous, active-low reset.
- `pll_lock`  in  1  raw PLL lock flag; asynchronous to `sys_clk`.
- `cfg_wr`  in  1  divisor write strobe, one cycle.
- `cfg_ch`  in  $clog2(CH_NUM) (min 1)  target channel.
- `cfg_div`  in  DIV_W  new divisor.
- `locked`  out  1  qualified lock; high in RUN.
- `rst_out_n`  out  1  synchronous active-low reset for downstream logic.
- `ce`  out  CH_NUM  per-channel one-cycle enable pulses.
- `clk_sq`  out  CH_NUM  per-channel square waves (macro-dependent).

## Operation
- `pll_lock` passes through a 2-flop synchroniser; only `lock_s` is used.
- FSM: WAIT_LOCK → STABLE when `lock_s`=1. STABLE counts consecutive `lock_s` cycles and moves to RUN at count LOCK_CYCLES−1. `lock_s`=0 in STABLE or RUN returns to WAIT_LOCK and clears the stability counter.
- `locked` = `rst_out_n` = registered (state==RUN).
- Reset values: state WAIT_LOCK; `locked`=0, `rst_out_n`=0, `ce`=0, `clk_sq`=0; every channel counter 0, active divisor = pending divisor = DIV_RST.
- Divisor D: `cfg_div`=0 is treated as 1. A channel counts 0..D−1 and wraps. `ce[i]` is registered and is high for exactly one cycle per wrap, giving rate f/D. D=1 gives continuous `ce`.
- Counters run only in RUN. Outside RUN, counters are held at 0 and `ce`/`clk_sq` are forced to 0.
- `cfg_wr` writes `cfg_div` to the pending register of `cfg_ch`. `cfg_ch` ≥ CH_NUM is ignored.
  - Outside RUN: active divisor takes the new value at the same clock edge.
  - In RUN: pending is copied to active at the next wrap, so periods never glitch. A write coinciding with a wrap becomes active for the period starting at that wrap.
  - Back-to-back writes to the same channel: last write wins.
- Lock loss mid-period: current period is abandoned, counters clear, `rst_out_n` drops the cycle after `lock_s` falls. Pending divisors are preserved.

## Timing
- Synchronous `sys_rst_n`, sampled on `sys_clk` rising edge; takes priority over all other inputs.
- `rst_out_n` rises exactly LOCK_CYCLES+2 cycles after the first `sys_clk` edge that samples `pll_lock`=1, provided lock stays high.
- First `ce[i]` pulse comes D cycles after `rst_out_n` rises; thereafter one pulse every D cycles.
- `rst_out_n` falls 3 cycles after `pll_lock` falls (2 synchroniser cycles + 1 output register).
- Channels are fully independent; all channels with equal D stay phase-aligned from release.

## Configuration
- `CLK_DIV_MGR_SQ_EN` defined:
  - `clk_sq[i]` toggles on every `ce[i]` pulse, giving f/(2D) at exact 50 % duty.
  - `clk_sq[i]` is cleared outside RUN.
- Undefined: `clk_sq` is tied to 0 and no toggle flops are built.

## Structure
- Package `clk_div_pkg` holds:
  - FSM state enum (WAIT_LOCK, STABLE, RUN).
  - Synchroniser depth constant (2).
  - `div_norm` function implementing the 0→1 mapping.
- Sub-module `clk_div_chan`, one instance per channel via generate. It contains the counter, active/pending divisor registers, `ce` register and optional `clk_sq` flop. Its inputs are `run`, `wr` and `div`.
- Top level contains the synchroniser, FSM, stability counter and `cfg_ch` decode.

## Test plan
- Reset, then `pll_lock`=1 with LOCK_CYCLES=16 → `rst_out_n`/`locked` rise exactly 18 cycles after first sampled lock; `ce`=0 throughout.
- D = {1, 2, 3, 5} on channels 0..3 → after release, `ce` periods are 1/2/3/5 cycles, first pulses at release+1/+2/+3/+5; with macro, `clk_sq` periods are 2/4/6/10 at 50 %.
- Channel 0 at D=4; write D=7 mid-period; write D=2 on an exact wrap cycle; write `cfg_ch`=5 with CH_NUM=4 → D=4 period completes before D=7 takes effect; D=2 is active from the wrap it coincides with; the out-of-range write changes nothing.
- Lock glitch: `pll_lock` low for 1 cycle during STABLE → counter restarts, release delayed by full LOCK_CYCLES; lock drop in RUN → `rst_out_n` low 3 cycles later, `ce` stops, re-release after LOCK_CYCLES+2.
- `cfg_div`=0 → behaves as D=1; `sys_rst_n` asserted in RUN → all outputs 0 next cycle and divisors back to DIV_RST.
